// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// It resolves load-use stalls, taken-branch flushes and data-memory freezes,
// traps freezes that last too long, and keeps saturating event counters.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   RUN   | normal flow; a freeze condition is entered through WAIT
//   WAIT  | data-memory access outstanding, counting freeze cycles
//   ERR   | freeze timeout; pipeline held until reset
module hazard_ctrl #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       id_rs_i,
   input  logic [4:0]       id_rt_i,
   input  logic             ex_memread_i,
   input  logic [4:0]       ex_rt_i,
   input  logic             branch_taken_i,
   input  logic             mem_req_i,
   input  logic             mem_ack_i,
   output logic             pc_write_o,
   output logic             ifid_hold_o,
   output logic             ifid_flush_o,
   output logic             idex_bubble_o,
   output logic             freeze_o,
   output logic             err_o,
   output logic [CNT_W-1:0] lu_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output logic [CNT_W-1:0] frz_cnt_o
);

   localparam logic [1:0] RUN  = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] ERR  = 2'd2;

   // A timeout of 1 would leave no room for the WAIT state to count.
   localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] wait_nxt;
   logic [WAIT_W-1:0] wait_inc;

   logic lu;
   logic frz;
   logic lu_evt;
   logic flush_evt;
   logic frz_evt;

   // Hazard terms; register zero is never a real dependency.
   assign lu  = ex_memread_i && (ex_rt_i != 5'd0) &&
                ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));
   assign frz = mem_req_i && !mem_ack_i;

   assign wait_inc = wait_cnt + 1'b1;

   // Next-state and wait counter. The freeze cycle spent in RUN counts toward
   // the timeout, so WAIT traps once its own count reaches TIMEOUT-1.
   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      case (state)
         RUN: begin
            if (frz) begin
               state_nxt = WAIT;
               wait_nxt  = '0;
            end
         end
         WAIT: begin
            if (!frz) begin
               state_nxt = RUN;
               wait_nxt  = '0;
            end else begin
               wait_nxt = wait_inc;
               if (wait_inc == WAIT_LAST) begin
                  state_nxt = ERR;
               end
            end
         end
         ERR: begin
            state_nxt = ERR;
         end
         default: begin
            state_nxt = ERR;
         end
      endcase
   end

   // State and wait counter registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= RUN;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
      end
   end

   // Pipeline controls by priority: error, freeze, flush, load-use.
   // During a freeze the branch and load-use terms are dropped on purpose;
   // ID is unchanged, so they are seen again once memory completes.
   always_comb begin
      pc_write_o    = 1'b1;
      ifid_hold_o   = 1'b0;
      ifid_flush_o  = 1'b0;
      idex_bubble_o = 1'b0;
      freeze_o      = 1'b0;
      lu_evt        = 1'b0;
      flush_evt     = 1'b0;
      frz_evt       = 1'b0;
      if (state == ERR) begin
         pc_write_o    = 1'b0;
         ifid_hold_o   = 1'b1;
         idex_bubble_o = 1'b1;
         freeze_o      = 1'b1;
         frz_evt       = 1'b1;
      end else if (frz) begin
         pc_write_o  = 1'b0;
         ifid_hold_o = 1'b1;
         freeze_o    = 1'b1;
         frz_evt     = 1'b1;
      end else if (branch_taken_i) begin
         ifid_flush_o = 1'b1;
         flush_evt    = 1'b1;
      end else if (lu) begin
         pc_write_o    = 1'b0;
         ifid_hold_o   = 1'b1;
         idex_bubble_o = 1'b1;
         lu_evt        = 1'b1;
      end
   end

   assign err_o = (state == ERR);

   // Load-use stall counter, saturating.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lu_cnt_o <= '0;
      end else if (lu_evt && (lu_cnt_o != CNT_MAX)) begin
         lu_cnt_o <= lu_cnt_o + 1'b1;
      end
   end

   // Taken-branch flush counter, saturating.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         flush_cnt_o <= '0;
      end else if (flush_evt && (flush_cnt_o != CNT_MAX)) begin
         flush_cnt_o <= flush_cnt_o + 1'b1;
      end
   end

   // Freeze cycle counter (error cycles included), saturating.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         frz_cnt_o <= '0;
      end else if (frz_evt && (frz_cnt_o != CNT_MAX)) begin
         frz_cnt_o <= frz_cnt_o + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (TIMEOUT=4, CNT_W=4).
`timescale 1ns/1ps
module tb_hazard_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [4:0] id_rs_i, id_rt_i, ex_rt_i;
   logic       ex_memread_i, branch_taken_i, mem_req_i, mem_ack_i;
   logic       pc_write_o, ifid_hold_o, ifid_flush_o, idex_bubble_o;
   logic       freeze_o, err_o;
   logic [3:0] lu_cnt_o, flush_cnt_o, frz_cnt_o;

   int n_cmp = 0;
   int n_bad = 0;

   hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
      .ex_memread_i(ex_memread_i), .ex_rt_i(ex_rt_i),
      .branch_taken_i(branch_taken_i),
      .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
      .pc_write_o(pc_write_o), .ifid_hold_o(ifid_hold_o),
      .ifid_flush_o(ifid_flush_o), .idex_bubble_o(idex_bubble_o),
      .freeze_o(freeze_o), .err_o(err_o),
      .lu_cnt_o(lu_cnt_o), .flush_cnt_o(flush_cnt_o), .frz_cnt_o(frz_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // Advance one edge, then settle 1ns past it.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      id_rs_i = 5'd0; id_rt_i = 5'd0; ex_rt_i = 5'd0;
      ex_memread_i = 1'b0; branch_taken_i = 1'b0;
      mem_req_i = 1'b0; mem_ack_i = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_i = 1'b1;
      #3;
      n_cmp++;
      if ({pc_write_o, ifid_hold_o, ifid_flush_o, idex_bubble_o, freeze_o, err_o} !== 6'b100000) begin
         n_bad++;
         $display("FAIL reset_outputs got %b want 100000",
                  {pc_write_o, ifid_hold_o, ifid_flush_o, idex_bubble_o, freeze_o, err_o});
      end
      step();
      n_cmp++;
      if ({lu_cnt_o, flush_cnt_o, frz_cnt_o} !== 12'h000) begin
         n_bad++;
         $display("FAIL reset_counters got %h want 000", {lu_cnt_o, flush_cnt_o, frz_cnt_o});
      end
      rst_i = 1'b0;
      #1;
   endtask

   task automatic test_load_use();
      do_reset();
      ex_memread_i = 1'b1; ex_rt_i = 5'd5; id_rs_i = 5'd5; id_rt_i = 5'd9;
      #1;
      n_cmp++;
      if ({pc_write_o, ifid_hold_o, idex_bubble_o, ifid_flush_o} !== 4'b0110) begin
         n_bad++;
         $display("FAIL lu_rs_stall got %b want 0110",
                  {pc_write_o, ifid_hold_o, idex_bubble_o, ifid_flush_o});
      end
      step();
      ex_memread_i = 1'b0;
      #1;
      n_cmp++;
      if ({pc_write_o, ifid_hold_o, idex_bubble_o} !== 3'b100 || lu_cnt_o !== 4'd1) begin
         n_bad++;
         $display("FAIL lu_release got %b cnt %0d want 100 cnt 1",
                  {pc_write_o, ifid_hold_o, idex_bubble_o}, lu_cnt_o);
      end
      // rt match
      ex_memread_i = 1'b1; ex_rt_i = 5'd7; id_rs_i = 5'd3; id_rt_i = 5'd7;
      #1;
      n_cmp++;
      if ({pc_write_o, ifid_hold_o, idex_bubble_o} !== 3'b011) begin
         n_bad++;
         $display("FAIL lu_rt_stall got %b want 011", {pc_write_o, ifid_hold_o, idex_bubble_o});
      end
      step();
      // match but not a load
      ex_memread_i = 1'b0;
      #1;
      n_cmp++;
      if (pc_write_o !== 1'b1 || lu_cnt_o !== 4'd2) begin
         n_bad++;
         $display("FAIL lu_not_load got pc %b cnt %0d want pc 1 cnt 2", pc_write_o, lu_cnt_o);
      end
      step();
   endtask

   task automatic test_reg_zero();
      do_reset();
      ex_memread_i = 1'b1; ex_rt_i = 5'd0; id_rt_i = 5'd0; id_rs_i = 5'd0;
      #1;
      n_cmp++;
      if ({pc_write_o, ifid_hold_o, idex_bubble_o} !== 3'b100) begin
         n_bad++;
         $display("FAIL reg_zero got %b want 100", {pc_write_o, ifid_hold_o, idex_bubble_o});
      end
      step();
      n_cmp++;
      if (lu_cnt_o !== 4'd0) begin
         n_bad++;
         $display("FAIL reg_zero_cnt got %0d want 0", lu_cnt_o);
      end
      idle_inputs();
   endtask

   task automatic test_flush_vs_lu();
      do_reset();
      ex_memread_i = 1'b1; ex_rt_i = 5'd12; id_rs_i = 5'd12; branch_taken_i = 1'b1;
      #1;
      n_cmp++;
      if ({ifid_flush_o, ifid_hold_o, pc_write_o, idex_bubble_o} !== 4'b1010) begin
         n_bad++;
         $display("FAIL flush_vs_lu got %b want 1010",
                  {ifid_flush_o, ifid_hold_o, pc_write_o, idex_bubble_o});
      end
      step();
      idle_inputs();
      #1;
      n_cmp++;
      if (flush_cnt_o !== 4'd1 || lu_cnt_o !== 4'd0) begin
         n_bad++;
         $display("FAIL flush_vs_lu_cnt got flush %0d lu %0d want 1 0", flush_cnt_o, lu_cnt_o);
      end
   endtask

   task automatic test_freeze();
      do_reset();
      mem_req_i = 1'b1; mem_ack_i = 1'b0; branch_taken_i = 1'b1;
      ex_memread_i = 1'b1; ex_rt_i = 5'd4; id_rs_i = 5'd4;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if ({freeze_o, ifid_flush_o, pc_write_o, ifid_hold_o, idex_bubble_o} !== 5'b10010) begin
            n_bad++;
            $display("FAIL freeze_cycle%0d got %b want 10010", i,
                     {freeze_o, ifid_flush_o, pc_write_o, ifid_hold_o, idex_bubble_o});
         end
         step();
      end
      ex_memread_i = 1'b0;
      mem_ack_i = 1'b1;
      #1;
      n_cmp++;
      if ({freeze_o, ifid_flush_o, pc_write_o} !== 3'b011) begin
         n_bad++;
         $display("FAIL freeze_ack got %b want 011", {freeze_o, ifid_flush_o, pc_write_o});
      end
      step();
      idle_inputs();
      #1;
      n_cmp++;
      if (frz_cnt_o !== 4'd3 || flush_cnt_o !== 4'd1 || lu_cnt_o !== 4'd0) begin
         n_bad++;
         $display("FAIL freeze_cnt got frz %0d flush %0d lu %0d want 3 1 0",
                  frz_cnt_o, flush_cnt_o, lu_cnt_o);
      end
      // Back in RUN with a cleared wait count: 3 fresh freeze cycles then drop, no error.
      mem_req_i = 1'b1;
      step(); step(); step();
      mem_req_i = 1'b0;
      step();
      n_cmp++;
      if (err_o !== 1'b0 || frz_cnt_o !== 4'd6) begin
         n_bad++;
         $display("FAIL freeze_rerun got err %b frz %0d want 0 6", err_o, frz_cnt_o);
      end
   endtask

   task automatic test_ack_corners();
      do_reset();
      mem_ack_i = 1'b1; mem_req_i = 1'b0;
      #1;
      n_cmp++;
      if (freeze_o !== 1'b0 || pc_write_o !== 1'b1) begin
         n_bad++;
         $display("FAIL ack_no_req got frz %b pc %b want 0 1", freeze_o, pc_write_o);
      end
      step();
      mem_req_i = 1'b1; mem_ack_i = 1'b1;
      #1;
      n_cmp++;
      if (freeze_o !== 1'b0) begin
         n_bad++;
         $display("FAIL ack_first_cycle got %b want 0", freeze_o);
      end
      step();
      idle_inputs();
      #1;
      n_cmp++;
      if (frz_cnt_o !== 4'd0) begin
         n_bad++;
         $display("FAIL ack_corner_cnt got %0d want 0", frz_cnt_o);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      mem_req_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_cmp++;
         if (err_o !== 1'b0 || freeze_o !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_pre%0d got err %b frz %b want 0 1", i, err_o, freeze_o);
         end
         step();
      end
      n_cmp++;
      if (err_o !== 1'b1 || frz_cnt_o !== 4'd4) begin
         n_bad++;
         $display("FAIL timeout_err got err %b frz_cnt %0d want 1 4", err_o, frz_cnt_o);
      end
      mem_req_i = 1'b0; branch_taken_i = 1'b1;
      #1;
      n_cmp++;
      if ({err_o, pc_write_o, ifid_hold_o, freeze_o, idex_bubble_o, ifid_flush_o} !== 6'b101110) begin
         n_bad++;
         $display("FAIL err_sticky got %b want 101110",
                  {err_o, pc_write_o, ifid_hold_o, freeze_o, idex_bubble_o, ifid_flush_o});
      end
      step();
      n_cmp++;
      if (err_o !== 1'b1 || frz_cnt_o !== 4'd5 || flush_cnt_o !== 4'd0) begin
         n_bad++;
         $display("FAIL err_hold got err %b frz %0d flush %0d want 1 5 0",
                  err_o, frz_cnt_o, flush_cnt_o);
      end
      #2;
      rst_i = 1'b1;
      #1;
      n_cmp++;
      if (err_o !== 1'b0 || {lu_cnt_o, flush_cnt_o, frz_cnt_o} !== 12'h000 || pc_write_o !== 1'b1) begin
         n_bad++;
         $display("FAIL async_rst got err %b cnts %h pc %b want 0 000 1",
                  err_o, {lu_cnt_o, flush_cnt_o, frz_cnt_o}, pc_write_o);
      end
      step();
      rst_i = 1'b0;
      idle_inputs();
      #1;
   endtask

   task automatic test_saturation();
      do_reset();
      ex_memread_i = 1'b1; ex_rt_i = 5'd31; id_rs_i = 5'd31;
      for (int i = 0; i < 20; i++) begin
         step();
         if (i == 14) begin
            n_cmp++;
            if (lu_cnt_o !== 4'd15) begin
               n_bad++;
               $display("FAIL sat_reach got %0d want 15", lu_cnt_o);
            end
         end
      end
      n_cmp++;
      if (lu_cnt_o !== 4'd15) begin
         n_bad++;
         $display("FAIL sat_hold got %0d want 15", lu_cnt_o);
      end
      idle_inputs();
   endtask

   initial begin
      rst_i = 1'b1;
      idle_inputs();
      test_reset();
      test_load_use();
      test_reg_zero();
      test_flush_vs_lu();
      test_freeze();
      test_ack_corners();
      test_timeout();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
